// File: rtl/serial_pkg.sv
// Shared helpers for the serial link (serialiser and deserialiser).
// Frame length and bit-counter width derived from word width and parity option.
package serial_pkg;

    // Bits on the wire per word: data bits plus an optional trailing parity bit.
    function automatic int unsigned frame_len(input int unsigned width, input bit parity);
        return parity ? width + 1 : width;
    endfunction

    // Counter width able to hold 0..f-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned f);
        return (f > 1) ? $clog2(f) : 1;
    endfunction

endpackage

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: assembles LSB-first bits into words and
// pulses parallel_valid for one cycle per completed word.
// Optional even-parity bit appended to each frame when
// SERIAL_TO_PARALLEL_PARITY_EN is defined.
module serial_to_parallel
    import serial_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_valid,
    input  logic             serial_data,
    input  logic             flush,
    output logic             busy,
    output logic             parallel_valid,
    output logic [width-1:0] parallel_data,
    output logic             parity_err
);

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif

    localparam int unsigned F  = frame_len(width, ParityEn);
    localparam int unsigned CW = cnt_width(F);

    logic [CW-1:0]    cnt_q;
    logic [width-1:0] shift_q, shift_d;
    logic [width-1:0] data_q;
    logic             valid_q;
    logic             accept, last;

    // Decode the accepted bit and drop it into the slot given by the counter.
    always_comb begin
        accept  = serial_valid && !flush;
        last    = accept && (cnt_q == CW'(F - 1));
        shift_d = shift_q;
        // The parity slot (cnt == width) has no data position, so it is never written.
        for (int unsigned i = 0; i < width; i++) begin
            if (accept && cnt_q == CW'(i)) begin
                shift_d[i] = serial_data;
            end
        end
    end

    // Bit counter: wraps on the last bit of a frame, cleared by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= last ? '0 : cnt_q + 1'b1;
        end
    end

    // Shift register collecting the partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
        end else if (flush || last) begin
            shift_q <= '0;
        end else if (accept) begin
            shift_q <= shift_d;
        end
    end

    // Output word and one-cycle valid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= last;
            if (last) begin
                data_q <= shift_d;
            end
        end
    end

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    logic perr_q;

    // Even parity over data plus the received parity bit, captured with the word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else if (last) begin
            perr_q <= (^shift_q) ^ serial_data;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign busy           = (cnt_q != '0);
    assign parallel_valid = valid_q;
    assign parallel_data  = data_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel (width = 8).
// Reference model: a queue of received bits, folded into a word once full.
module tb_serial_to_parallel;

    localparam int W = 8;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         serial_valid = 1'b0;
    logic         serial_data = 1'b0;
    logic         flush = 1'b0;
    logic         busy;
    logic         parallel_valid;
    logic [W-1:0] parallel_data;
    logic         parity_err;

    serial_to_parallel #(.width(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_valid   (serial_valid),
        .serial_data    (serial_data),
        .flush          (flush),
        .busy           (busy),
        .parallel_valid (parallel_valid),
        .parallel_data  (parallel_data),
        .parity_err     (parity_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Reference model state.
    bit           model_q[$];
    logic         exp_pv   = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic         exp_busy = 1'b0;
    logic         exp_perr = 1'b0;

    // Frame bits for a word: data LSB first, then correct even parity if enabled.
    function automatic logic [F-1:0] frame_of(input logic [W-1:0] w);
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    // Drive one cycle of stimulus and advance the model; sampling is 1 time unit after the edge.
    task automatic step(input bit v, input bit d, input bit f);
        logic [W-1:0] word;
        @(negedge clk);
        serial_valid = v;
        serial_data  = d;
        flush        = f;
        @(posedge clk);
        exp_pv = 1'b0;
        if (f) begin
            model_q.delete();
        end else if (v) begin
            model_q.push_back(d);
            if (model_q.size() == F) begin
                for (int k = 0; k < W; k++) word[k] = model_q[k];
                exp_pv   = 1'b1;
                exp_data = word;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
                exp_perr = (^word) ^ model_q[W];
`else
                exp_perr = 1'b0;
`endif
                model_q.delete();
            end
        end
        exp_busy = (model_q.size() != 0);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        total++;
        if (busy !== 1'b0 || parallel_valid !== 1'b0 || parallel_data !== '0
            || parity_err !== 1'b0) begin
            $display("FAIL reset: got busy=%b pv=%b data=%h perr=%b, want all 0",
                     busy, parallel_valid, parallel_data, parity_err);
        end else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [F-1:0] fr = frame_of(8'hA5);
        int pulses = 0;
        for (int k = 0; k < F; k++) begin
            step(1'b1, fr[k], 1'b0);
            if (parallel_valid) pulses++;
            total++;
            if (parallel_valid !== exp_pv || parallel_data !== exp_data || busy !== exp_busy
                || parity_err !== exp_perr) begin
                $display("FAIL basic bit%0d: got pv=%b data=%h busy=%b perr=%b, want %b %h %b %b",
                         k, parallel_valid, parallel_data, busy, parity_err,
                         exp_pv, exp_data, exp_busy, exp_perr);
            end else passed++;
        end
        total++;
        if (pulses !== 1 || parallel_data !== 8'hA5) begin
            $display("FAIL basic_word: got pulses=%0d data=%h, want 1 a5", pulses, parallel_data);
        end else passed++;
        step(1'b0, 1'b0, 1'b0);
        total++;
        if (parallel_valid !== 1'b0 || parallel_data !== 8'hA5) begin
            $display("FAIL basic_hold: got pv=%b data=%h, want 0 a5", parallel_valid,
                     parallel_data);
        end else passed++;
    endtask

    task automatic test_gaps();
        logic [F-1:0] fr = frame_of(8'h3C);
        int pulses = 0;
        for (int k = 0; k < F; k++) begin
            int g = $urandom_range(0, 3);
            for (int j = 0; j < g; j++) begin
                step(1'b0, 1'($urandom), 1'b0);
                total++;
                if (parallel_valid !== exp_pv || parallel_data !== exp_data
                    || busy !== exp_busy) begin
                    $display("FAIL gaps gap: got pv=%b data=%h busy=%b, want %b %h %b",
                             parallel_valid, parallel_data, busy, exp_pv, exp_data, exp_busy);
                end else passed++;
            end
            step(1'b1, fr[k], 1'b0);
            if (parallel_valid) pulses++;
            total++;
            if (parallel_valid !== exp_pv || parallel_data !== exp_data || busy !== exp_busy
                || parity_err !== exp_perr) begin
                $display("FAIL gaps bit%0d: got pv=%b data=%h busy=%b perr=%b, want %b %h %b %b",
                         k, parallel_valid, parallel_data, busy, parity_err,
                         exp_pv, exp_data, exp_busy, exp_perr);
            end else passed++;
        end
        total++;
        if (pulses !== 1 || parallel_data !== 8'h3C) begin
            $display("FAIL gaps_word: got pulses=%0d data=%h, want 1 3c", pulses, parallel_data);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        logic [2*F-1:0] fr = {frame_of(8'hFF), frame_of(8'h01)};
        int pcyc[$];
        logic [W-1:0] words[$];
        for (int k = 0; k < 2 * F; k++) begin
            step(1'b1, fr[k], 1'b0);
            if (parallel_valid) begin
                pcyc.push_back(cyc);
                words.push_back(parallel_data);
            end
            total++;
            if (parallel_valid !== exp_pv || parallel_data !== exp_data || busy !== exp_busy) begin
                $display("FAIL b2b bit%0d: got pv=%b data=%h busy=%b, want %b %h %b",
                         k, parallel_valid, parallel_data, busy, exp_pv, exp_data, exp_busy);
            end else passed++;
        end
        total++;
        if (pcyc.size() != 2) begin
            $display("FAIL b2b_pulses: got %0d pulses, want 2", pcyc.size());
        end else if (pcyc[1] - pcyc[0] != F || words[0] !== 8'h01 || words[1] !== 8'hFF) begin
            $display("FAIL b2b_spacing: got gap=%0d words=%h,%h, want %0d 01,ff",
                     pcyc[1] - pcyc[0], words[0], words[1], F);
        end else passed++;
    endtask

    task automatic test_flush();
        logic [F-1:0] fa = frame_of(8'hAA);
        logic [F-1:0] f5 = frame_of(8'h55);
        logic [F-1:0] f8 = frame_of(8'h81);
        int pulses = 0;
        for (int k = 0; k < 5; k++) step(1'b1, fa[k], 1'b0);
        step(1'b0, 1'b0, 1'b1);
        total++;
        if (parallel_valid !== 1'b0 || busy !== 1'b0 || parallel_data !== exp_data) begin
            $display("FAIL flush_idle: got pv=%b busy=%b data=%h, want 0 0 %h",
                     parallel_valid, busy, parallel_data, exp_data);
        end else passed++;
        for (int k = 0; k < F; k++) begin
            step(1'b1, f5[k], 1'b0);
            if (parallel_valid) pulses++;
        end
        total++;
        if (pulses !== 1 || parallel_data !== 8'h55 || busy !== 1'b0) begin
            $display("FAIL flush_word: got pulses=%0d data=%h busy=%b, want 1 55 0",
                     pulses, parallel_data, busy);
        end else passed++;
        // Flush arriving together with the completing bit must swallow it.
        for (int k = 0; k < F - 1; k++) step(1'b1, f8[k], 1'b0);
        step(1'b1, f8[F-1], 1'b1);
        total++;
        if (parallel_valid !== 1'b0 || parallel_data !== 8'h55 || busy !== 1'b0) begin
            $display("FAIL flush_last: got pv=%b data=%h busy=%b, want 0 55 0",
                     parallel_valid, parallel_data, busy);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        logic [F-1:0] fh = frame_of(8'hF0);
        logic [F-1:0] fl = frame_of(8'h0F);
        for (int k = 0; k < 4; k++) step(1'b1, fh[k], 1'b0);
        @(negedge clk);
        serial_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || parallel_valid !== 1'b0 || parallel_data !== '0
            || parity_err !== 1'b0) begin
            $display("FAIL reset_mid: got busy=%b pv=%b data=%h perr=%b, want all 0",
                     busy, parallel_valid, parallel_data, parity_err);
        end else passed++;
        model_q.delete();
        exp_pv = 1'b0; exp_data = '0; exp_busy = 1'b0; exp_perr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < F; k++) step(1'b1, fl[k], 1'b0);
        total++;
        if (parallel_valid !== 1'b1 || parallel_data !== 8'h0F) begin
            $display("FAIL reset_resume: got pv=%b data=%h, want 1 0f",
                     parallel_valid, parallel_data);
        end else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [F-1:0] fr = frame_of(W'($urandom));
            for (int k = 0; k < F; k++) begin
                if ($urandom_range(0, 2) == 0) step(1'b0, 1'($urandom), 1'b0);
                step(1'b1, fr[k], 1'b0);
                total++;
                if (parallel_valid !== exp_pv || parallel_data !== exp_data
                    || busy !== exp_busy || parity_err !== exp_perr) begin
                    $display("FAIL random w%0d b%0d: got pv=%b data=%h busy=%b perr=%b, want %b %h %b %b",
                             n, k, parallel_valid, parallel_data, busy, parity_err,
                             exp_pv, exp_data, exp_busy, exp_perr);
                end else passed++;
            end
        end
    endtask

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    task automatic test_parity();
        logic [F-1:0] good = frame_of(8'hA5);
        logic [F-1:0] bad;
        bad = good;
        bad[W] = ~bad[W];
        for (int k = 0; k < F; k++) step(1'b1, good[k], 1'b0);
        total++;
        if (parallel_valid !== 1'b1 || parallel_data !== 8'hA5 || parity_err !== 1'b0) begin
            $display("FAIL parity_good: got pv=%b data=%h perr=%b, want 1 a5 0",
                     parallel_valid, parallel_data, parity_err);
        end else passed++;
        for (int k = 0; k < F; k++) step(1'b1, bad[k], 1'b0);
        total++;
        if (parallel_valid !== 1'b1 || parallel_data !== 8'hA5 || parity_err !== 1'b1) begin
            $display("FAIL parity_bad: got pv=%b data=%h perr=%b, want 1 a5 1",
                     parallel_valid, parallel_data, parity_err);
        end else passed++;
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
